// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes on both sides and STAGES register stages.
// Optional accumulated-overflow flag is built only when ALU_PIPE_STICKY_OVF_EN is defined.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] R2,
    input  logic [WIDTH-1:0] R3,
    input  logic [2:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R0,
    output logic             overflow,
    output logic             zero,
    output logic             carry,
    output logic             ovf_sticky,
    input  logic             sticky_clr
);

    // Stage payload layout: {result, overflow, zero, carry}
    localparam int DW = WIDTH + 3;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_NOT = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_OR  = 3'b100,
        OP_AND = 3'b101,
        OP_XOR = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    // SUB shares the adder: operand B inverted with a carry-in of one.
    function automatic logic [DW-1:0] alu_compute(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        logic [WIDTH:0]   sum_v;
        logic [WIDTH-1:0] b_v;
        logic [WIDTH-1:0] res_v;
        logic             ovf_v;
        logic             cy_v;
        b_v   = (op == OP_SUB) ? ~b : b;
        sum_v = {1'b0, a} + {1'b0, b_v} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        res_v = {WIDTH{1'b0}};
        ovf_v = 1'b0;
        cy_v  = 1'b0;
        case (op)
            OP_MOV: res_v = a;
            OP_NOT: res_v = ~a;
            OP_ADD, OP_SUB: begin
                res_v = sum_v[WIDTH-1:0];
                cy_v  = sum_v[WIDTH];
                ovf_v = (a[WIDTH-1] == b_v[WIDTH-1]) && (res_v[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  res_v = a | b;
            OP_AND: res_v = a & b;
            OP_XOR: res_v = a ^ b;
            OP_SLT: res_v = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: res_v = {WIDTH{1'b0}};
        endcase
        return {res_v, ovf_v, (res_v == {WIDTH{1'b0}}), cy_v};
    endfunction

    logic [STAGES-1:0] valid_r;
    logic [DW-1:0]     data_r [STAGES];
    logic [STAGES-1:0] adv_s;
    logic [DW-1:0]     comp_s;

    assign comp_s = alu_compute(R2, R3, ALUOp);

    // Stall chain from the output end: a stage advances when empty or when its successor advances.
    always_comb begin
        logic chain_v;
        chain_v            = !valid_r[STAGES-1] || out_ready;
        adv_s              = {STAGES{1'b0}};
        adv_s[STAGES-1]    = chain_v;
        for (int k = STAGES - 2; k >= 0; k--) begin
            chain_v  = !valid_r[k] || chain_v;
            adv_s[k] = chain_v;
        end
    end

    // Stage registers; payloads only load with valid data so bubbles never disturb held outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= {DW{1'b0}};
            end
        end else begin
            if (adv_s[0]) begin
                valid_r[0] <= in_valid;
                if (in_valid) begin
                    data_r[0] <= comp_s;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv_s[k]) begin
                    valid_r[k] <= valid_r[k-1];
                    if (valid_r[k-1]) begin
                        data_r[k] <= data_r[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = valid_r[STAGES-1];
    assign R0        = data_r[STAGES-1][DW-1:3];
    assign overflow  = data_r[STAGES-1][2];
    assign zero      = data_r[STAGES-1][1];
    assign carry     = data_r[STAGES-1][0];

`ifdef ALU_PIPE_STICKY_OVF_EN
    logic out_xfer_s;
    logic ovf_sticky_r;

    assign out_xfer_s = out_valid && out_ready;

    // Accumulated overflow: a new overflowing transfer takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_r <= 1'b0;
        end else if (out_xfer_s && overflow) begin
            ovf_sticky_r <= 1'b1;
        end else if (sticky_clr) begin
            ovf_sticky_r <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_sticky_r;
`else
    logic unused_sticky_clr_s;
    assign unused_sticky_clr_s = sticky_clr;
    assign ovf_sticky          = 1'b0;
`endif

    alu_pipe_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R0        (R0),
        .overflow  (overflow),
        .zero      (zero),
        .carry     (carry)
    );

endmodule

// Handshake properties of alu_pipe: stalled outputs hold, and a draining output never blocks input.
module alu_pipe_checker #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] R0,
    input logic             overflow,
    input logic             zero,
    input logic             carry
);

    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(R0) && $stable({overflow, zero, carry})));

    a_ready_when_draining: assert property (@(posedge clk) disable iff (rst)
        out_ready |-> in_ready);

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, stall burst, reset flush,
// sticky overflow behaviour and a randomised stream against an arithmetic reference model.
module tb_alu_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  R2;
    logic [WIDTH-1:0]  R3;
    logic [2:0]        ALUOp;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  R0;
    logic              overflow;
    logic              zero;
    logic              carry;
    logic              ovf_sticky;
    logic              sticky_clr;

    typedef struct packed {
        logic [31:0] r;
        logic        ovf;
        logic        z;
        logic        c;
    } res_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        res_t        exp;
    } vec_t;

    localparam logic [2:0] ADD = 3'b010;

    int          total;
    int          bad;
    int          accepted;
    int          delivered;
    res_t        sb_q[$];
    logic        stall_pending;
    logic [34:0] stall_snap;
    vec_t        vecs[13];

    alu_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .R2         (R2),
        .R3         (R3),
        .ALUOp      (ALUOp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .R0         (R0),
        .overflow   (overflow),
        .zero       (zero),
        .carry      (carry),
        .ovf_sticky (ovf_sticky),
        .sticky_clr (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, test completion required");
        $fatal(1, "watchdog");
    end

    // Reference: signed and unsigned results computed with wide integer arithmetic.
    function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t   m;
        longint sa;
        longint sb;
        longint s;
        longint ua;
        longint ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        m  = '0;
        case (op)
            3'd0: m.r = a;
            3'd1: m.r = ~a;
            3'd2: begin
                m.r   = a + b;
                m.c   = (ua + ub) > 64'sd4294967295;
                s     = sa + sb;
                m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd3: begin
                m.r   = a - b;
                m.c   = (ua >= ub);
                s     = sa - sb;
                m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd4: m.r = a | b;
            3'd5: m.r = a & b;
            3'd6: m.r = a ^ b;
            default: m.r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        m.z = (m.r == 32'd0);
        return m;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock with scoreboard bookkeeping; inputs are set by the caller just after posedge.
    task automatic run_cycle();
        res_t e;
        @(negedge clk);
        if (stall_pending) begin
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_hold", {29'd0, R0, overflow, zero, carry}, {29'd0, stall_snap});
        end
        stall_pending = out_valid && !out_ready;
        stall_snap    = {R0, overflow, zero, carry};
        if (out_valid && out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got R0=%h with no outstanding op", R0);
            end else begin
                e = sb_q.pop_front();
                total--;
                check("out_result", {29'd0, R0, overflow, zero, carry}, {29'd0, e});
                delivered++;
            end
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(model(ALUOp, R2, R3));
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_and_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat);
        ALUOp     = op;
        R2        = a;
        R3        = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        total         = 0;
        bad           = 0;
        accepted      = 0;
        delivered     = 0;
        stall_pending = 1'b0;
        stall_snap    = '0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        sticky_clr    = 1'b0;
        R2            = 32'd0;
        R3            = 32'd0;
        ALUOp         = 3'd0;

        vecs[0]  = '{3'd2, 32'h7FFF_FFFF, 32'h0000_0001, {32'h8000_0000, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 1'b0, 1'b1, 1'b1}};
        vecs[2]  = '{3'd3, 32'h0000_0005, 32'h0000_0005, {32'h0000_0000, 1'b0, 1'b1, 1'b1}};
        vecs[3]  = '{3'd3, 32'h0000_0003, 32'h0000_0005, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0001, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{3'd6, 32'hA5A5_A5A5, 32'hA5A5_A5A5, {32'h0000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[6]  = '{3'd0, 32'h1234_5678, 32'hDEAD_BEEF, {32'h1234_5678, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{3'd1, 32'h0000_0000, 32'h0000_0000, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{3'd4, 32'hF0F0_F0F0, 32'h0F0F_0F0F, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        vecs[9]  = '{3'd5, 32'hF0F0_F0F0, 32'h0F0F_0F0F, {32'h0000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[10] = '{3'd3, 32'h8000_0000, 32'h0000_0001, {32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1}};
        vecs[11] = '{3'd7, 32'h0000_0001, 32'hFFFF_FFFF, {32'h0000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[12] = '{3'd2, 32'h8000_0000, 32'h8000_0000, {32'h0000_0000, 1'b1, 1'b1, 1'b1}};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outputs", {29'd0, R0, overflow, zero, carry}, 64'd0);
        check("rst_sticky", {63'd0, ovf_sticky}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors: fixed latency and exact results.
        for (int i = 0; i < 13; i++) begin
            issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES));
            check($sformatf("vec%0d_result", i), {29'd0, R0, overflow, zero, carry}, {29'd0, vecs[i].exp});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_drained", i), {63'd0, out_valid}, 64'd0);
        end

        // Burst of 8 ADDs with the consumer stalled for cycles 3..6.
        accepted  = 0;
        delivered = 0;
        for (int c = 0; c < 60 && delivered < 8; c++) begin
            in_valid  = (accepted < 8);
            ALUOp     = ADD;
            R2        = $urandom;
            R3        = $urandom;
            out_ready = !(c >= 3 && c <= 6);
            #2;
            if (c >= 3 && c <= 6) begin
                check("burst_in_ready_low", {63'd0, in_ready}, 64'd0);
                check("burst_out_valid", {63'd0, out_valid}, 64'd1);
            end
            run_cycle();
        end
        in_valid = 1'b0;
        check("burst_accepted", 64'(accepted), 64'd8);
        check("burst_delivered", 64'(delivered), 64'd8);

`ifdef ALU_PIPE_STICKY_OVF_EN
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        check("sticky_init_clr", {63'd0, ovf_sticky}, 64'd0);
        issue_and_wait(ADD, 32'h7FFF_FFFF, 32'h1, lat);
        @(posedge clk);
        #1;
        check("sticky_set", {63'd0, ovf_sticky}, 64'd1);
        issue_and_wait(ADD, 32'h1, 32'h2, lat);
        @(posedge clk);
        #1;
        check("sticky_hold", {63'd0, ovf_sticky}, 64'd1);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        check("sticky_clear", {63'd0, ovf_sticky}, 64'd0);
        issue_and_wait(ADD, 32'h7FFF_FFFF, 32'h1, lat);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        check("sticky_set_wins", {63'd0, ovf_sticky}, 64'd1);
`else
        issue_and_wait(ADD, 32'h7FFF_FFFF, 32'h1, lat);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        check("sticky_absent", {63'd0, ovf_sticky}, 64'd0);
`endif

        // Randomised stream with random upstream gaps and downstream stalls.
        accepted  = 0;
        delivered = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            ALUOp     = 3'($urandom % 8);
            R2        = pick();
            R3        = pick();
            run_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
            run_cycle();
        end
        check("random_drain_empty", 64'(sb_q.size()), 64'd0);
        check("random_balance", 64'(delivered), 64'(accepted));

        // Reset with two results in flight: everything in flight is discarded.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ALUOp     = ADD;
        R2        = 32'h7FFF_FFFF;
        R3        = 32'h1;
        run_cycle();
        R2 = 32'h0000_0010;
        R3 = 32'h0000_0020;
        run_cycle();
        check("pre_rst_full", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_outputs", {29'd0, R0, overflow, zero, carry}, 64'd0);
        check("flush_sticky", {63'd0, ovf_sticky}, 64'd0);
        rst = 1'b0;
        sb_q.delete();
        stall_pending = 1'b0;
        out_ready     = 1'b1;
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        for (int c = 0; c < 6; c++) begin
            check("flush_no_stale", {63'd0, out_valid}, 64'd0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
